gate_truth_table_checker: RTL

//  Synthesizable stimulus/response engine for 2-input logic gates under test (GUT).
//  On start, drives every {a,b} combination into the GUT, samples its output after a

---
 rtl/gate_truth_table_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gate_truth_table_checker.sv
// Stimulus/response engine for a 2-input gate under test: sweeps every {a,b} vector,
// samples the gate output after a settle window and compares it to a truth table.
module gate_truth_table_checker #(
    parameter logic [3:0] TRUTH         = 4'b0001,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         N_PASSES      = 1,
    parameter int         ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(N_PASSES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

    logic [1:0]        state_q,    state_d;
    logic [1:0]        idx_q,      idx_d;
    logic [1:0]        ab_q,       ab_d;
    logic [SET_W-1:0]  settle_q,   settle_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [ERR_W-1:0]  err_q,      err_d;
    logic [3:0]        fail_q,     fail_d;
    logic              pass_q,     pass_d;

    logic              mismatch;
    logic [ERR_W-1:0]  err_sat;

    assign mismatch = (y_in != TRUTH[idx_q]);
    assign err_sat  = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        idx_d      = idx_q;
        ab_d       = ab_q;
        settle_d   = settle_q;
        pass_cnt_d = pass_cnt_q;
        err_d      = err_q;
        fail_d     = fail_q;
        pass_d     = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_DRIVE;
                    idx_d      = 2'd0;
                    ab_d       = 2'd0;
                    settle_d   = '0;
                    pass_cnt_d = '0;
                    err_d      = '0;
                    fail_d     = 4'd0;
                    pass_d     = 1'b0;
                end
            end
            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = S_SAMPLE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d         = err_sat;
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    ab_d    = idx_q + 2'd1;
                    state_d = S_DRIVE;
                end else if (pass_cnt_q != PASS_LAST) begin
                    idx_d      = 2'd0;
                    ab_d       = 2'd0;
                    pass_cnt_d = pass_cnt_q + PASS_W'(1);
                    state_d    = S_DRIVE;
                end else begin
                    // Verdict must include this final sample, so it is taken from the pre-update count.
                    ab_d    = 2'd0;
                    pass_d  = (err_q == '0) && !mismatch;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            ab_q       <= 2'd0;
            settle_q   <= '0;
            pass_cnt_q <= '0;
            err_q      <= '0;
            fail_q     <= 4'd0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ab_q       <= ab_d;
            settle_q   <= settle_d;
            pass_cnt_q <= pass_cnt_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
            pass_q     <= pass_d;
        end
    end

    assign a_out     = ab_q[1];
    assign b_out     = ab_q[0];
    assign busy      = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
